vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA timing controller. It generates hsync, vsync, video_active and pixel coordinates for any mode set by parameters.
- Adds a pixel clock-enable (so clk may run faster than the pixel rate), programmable sync polarity, a run enable, and line/frame/vblank event pulses for downstream character, framebuffer and interrupt logic.
- All outputs are registered. It sits between the system clock domain and the video colour path.

---
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 tb/tb_vga_timing_gen.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised raster timing generator with pixel clock-enable,
//            programmable sync polarity, run enable and event pulses.
// Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FRONT  = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FRONT  = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CNT_W    = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pix_ce,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_active,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start,
    output logic             vblank_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Inclusive upper bounds keep every constant representable in CNT_W bits
    // even when a total equals 2^CNT_W.
    localparam logic [CNT_W-1:0] c_H_LAST     = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST     = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] c_V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] c_V_ACTIVE   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_HS_FIRST   = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] c_HS_LAST    = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] c_VS_FIRST   = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] c_VS_LAST    = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;

    logic             w_h_wrap;
    logic [CNT_W-1:0] w_h_nxt;
    logic [CNT_W-1:0] w_v_nxt;
    logic             w_hs_on;
    logic             w_vs_on;
    logic             w_act;
    logic             w_h_zero;

    always_comb begin
        w_h_wrap = (r_h == c_H_LAST);
        w_h_nxt  = w_h_wrap ? '0 : r_h + CNT_W'(1);
        w_v_nxt  = r_v;
        if (w_h_wrap) begin
            w_v_nxt = (r_v == c_V_LAST) ? '0 : r_v + CNT_W'(1);
        end
    end

    // Outputs are decoded from the count being loaded, so they line up with
    // the counters on the same edge.
    always_comb begin
        w_hs_on  = (w_h_nxt >= c_HS_FIRST) && (w_h_nxt <= c_HS_LAST);
        w_vs_on  = (w_v_nxt >= c_VS_FIRST) && (w_v_nxt <= c_VS_LAST);
        w_act    = (w_h_nxt <= c_H_ACT_LAST) && (w_v_nxt <= c_V_ACT_LAST);
        w_h_zero = (w_h_nxt == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h          <= c_H_LAST;
            r_v          <= c_V_LAST;
            hsync        <= ~HS_POL;
            vsync        <= ~VS_POL;
            video_active <= 1'b0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else if (!en) begin
            // Parking at the last position makes the next advance land on (0,0).
            r_h          <= c_H_LAST;
            r_v          <= c_V_LAST;
            hsync        <= ~HS_POL;
            vsync        <= ~VS_POL;
            video_active <= 1'b0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else if (pix_ce) begin
            r_h          <= w_h_nxt;
            r_v          <= w_v_nxt;
            hsync        <= w_hs_on ? HS_POL : ~HS_POL;
            vsync        <= w_vs_on ? VS_POL : ~VS_POL;
            video_active <= w_act;
            pixel_x      <= w_act ? w_h_nxt : '0;
            pixel_y      <= w_act ? w_v_nxt : '0;
            line_start   <= w_h_zero;
            frame_start  <= w_h_zero && (w_v_nxt == '0);
            vblank_start <= w_h_zero && (w_v_nxt == c_V_ACTIVE);
        end else begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench for vga_timing_gen in default and small modes.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic [9:0] px;
        logic [9:0] py;
        logic       ls;
        logic       fs;
        logic       vb;
    } vout_t;

    localparam int A_HT = 800;
    localparam int A_VT = 525;
    localparam int B_HT = 8;
    localparam int B_VT = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en_a = 1'b0, ce_a = 1'b0, en_b = 1'b0, ce_b = 1'b0;

    logic       hs_a, vs_a, act_a, ls_a, fs_a, vb_a;
    logic [9:0] px_a, py_a;
    logic       hs_b, vs_b, act_b, ls_b, fs_b, vb_b;
    logic [3:0] px_b, py_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_a (
        .clk(clk), .reset_n(reset_n), .pix_ce(ce_a), .en(en_a),
        .hsync(hs_a), .vsync(vs_a), .video_active(act_a),
        .pixel_x(px_a), .pixel_y(py_a),
        .line_start(ls_a), .frame_start(fs_a), .vblank_start(vb_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .pix_ce(ce_b), .en(en_b),
        .hsync(hs_b), .vsync(vs_b), .video_active(act_b),
        .pixel_x(px_b), .pixel_y(py_b),
        .line_start(ls_b), .frame_start(fs_b), .vblank_start(vb_b)
    );

    vout_t got_a, got_b;
    assign got_a = {hs_a, vs_a, act_a, px_a, py_a, ls_a, fs_a, vb_a};
    assign got_b = {hs_b, vs_b, act_b, 6'd0, px_b, 6'd0, py_b, ls_b, fs_b, vb_b};

    // ---------------- reference model: raster position as plain integers
    function automatic vout_t decode(int h, int v, int ha, int hf, int hsw,
                                     int va, int vf, int vsw, bit hp, bit vp);
        vout_t o;
        o.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
        o.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
        o.act = (h < ha) && (v < va);
        o.px  = o.act ? 10'(h) : 10'd0;
        o.py  = o.act ? 10'(v) : 10'd0;
        o.ls  = (h == 0);
        o.fs  = (h == 0) && (v == 0);
        o.vb  = (h == 0) && (v == va);
        return o;
    endfunction

    function automatic vout_t idle_val(bit hp, bit vp);
        vout_t o = '0;
        o.hs = !hp;
        o.vs = !vp;
        return o;
    endfunction

    int mh_a, mv_a, mh_b, mv_b;
    int nh_a, nv_a, nh_b, nv_b;
    vout_t exp_a, exp_b;
    assign nh_a = (mh_a + 1) % A_HT;
    assign nv_a = (mh_a == A_HT - 1) ? (mv_a + 1) % A_VT : mv_a;
    assign nh_b = (mh_b + 1) % B_HT;
    assign nv_b = (mh_b == B_HT - 1) ? (mv_b + 1) % B_VT : mv_b;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || !en_a) begin
            mh_a  <= A_HT - 1;
            mv_a  <= A_VT - 1;
            exp_a <= idle_val(1'b0, 1'b0);
        end else if (ce_a) begin
            mh_a  <= nh_a;
            mv_a  <= nv_a;
            exp_a <= decode(nh_a, nv_a, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0);
        end else begin
            exp_a.ls <= 1'b0;
            exp_a.fs <= 1'b0;
            exp_a.vb <= 1'b0;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || !en_b) begin
            mh_b  <= B_HT - 1;
            mv_b  <= B_VT - 1;
            exp_b <= idle_val(1'b1, 1'b1);
        end else if (ce_b) begin
            mh_b  <= nh_b;
            mv_b  <= nv_b;
            exp_b <= decode(nh_b, nv_b, 4, 1, 2, 3, 1, 1, 1'b1, 1'b1);
        end else begin
            exp_b.ls <= 1'b0;
            exp_b.fs <= 1'b0;
            exp_b.vb <= 1'b0;
        end
    end

    // ---------------- stimulus helpers (drive only, no checking)
    task automatic tick_a(bit e, bit c);
        en_a = e; ce_a = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick_b(bit e, bit c);
        en_b = e; ce_b = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests
    task automatic test_reset();
        vout_t ea, eb;
        ea = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 3'b000};
        eb = {1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 3'b000};
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (got_a !== ea) begin
            errors++; $display("FAIL reset_a: got %h want %h", got_a, ea);
        end
        checks++;
        if (got_b !== eb) begin
            errors++; $display("FAIL reset_b: got %h want %h", got_b, eb);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_default_run();
        vout_t e0;
        int first_low, low_cnt, last_ls, vs_act;
        e0 = {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 3'b110};
        tick_a(1, 1);
        checks++;
        if (got_a !== e0) begin
            errors++; $display("FAIL first_edge: got %h want %h", got_a, e0);
        end
        first_low = -1; low_cnt = 0; last_ls = 0; vs_act = 0;
        for (int k = 1; k < 2400; k++) begin
            tick_a(1, 1);
            checks++;
            if (got_a !== exp_a) begin
                errors++; $display("FAIL default_k%0d: got %h want %h", k, got_a, exp_a);
            end
            if (k < 800 && hs_a === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = k;
            end
            if (vs_a !== 1'b1) vs_act++;
            if (ls_a === 1'b1) begin
                checks++;
                if (k - last_ls != 800) begin
                    errors++; $display("FAIL line_period: got %0d want 800", k - last_ls);
                end
                last_ls = k;
            end
        end
        checks++;
        if (first_low != 656 || low_cnt != 96) begin
            errors++; $display("FAIL hsync_window: start %0d len %0d want 656 96", first_low, low_cnt);
        end
        checks++;
        if (last_ls != 1600 || vs_act != 0) begin
            errors++; $display("FAIL line_count: last_ls %0d vs_act %0d want 1600 0", last_ls, vs_act);
        end
    endtask

    task automatic test_ce_div4();
        int ls_cnt, last_ls, prev_ls;
        ls_cnt = 0; last_ls = -1; prev_ls = 0;
        for (int k = 0; k < 6400; k++) begin
            tick_a(1, (k % 4) == 0);
            checks++;
            if (got_a !== exp_a) begin
                errors++; $display("FAIL ce4_k%0d: got %h want %h", k, got_a, exp_a);
            end
            if (ls_a === 1'b1) begin
                ls_cnt++;
                checks++;
                if (prev_ls != 0 || (last_ls >= 0 && k - last_ls != 3200)) begin
                    errors++; $display("FAIL ce4_ls: at %0d prev %0d last %0d want period 3200 width 1", k, prev_ls, last_ls);
                end
                last_ls = k;
            end
            prev_ls = int'(ls_a);
        end
        checks++;
        if (ls_cnt != 2) begin
            errors++; $display("FAIL ce4_ls_count: got %0d want 2", ls_cnt);
        end
    endtask

    task automatic test_en_drop();
        vout_t eidle, e0, epos;
        eidle = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 3'b000};
        e0    = {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 3'b110};
        epos  = {1'b1, 1'b1, 1'b1, 10'd100, 10'd2, 3'b000};
        tick_a(0, 0);
        tick_a(1, 1);
        for (int k = 0; k < 1700; k++) tick_a(1, 1);
        checks++;
        if (got_a !== epos) begin
            errors++; $display("FAIL en_pos: got %h want %h", got_a, epos);
        end
        tick_a(0, 1);
        checks++;
        if (got_a !== eidle) begin
            errors++; $display("FAIL en_drop: got %h want %h", got_a, eidle);
        end
        tick_a(1, 0);
        checks++;
        if (got_a !== eidle) begin
            errors++; $display("FAIL en_hold: got %h want %h", got_a, eidle);
        end
        tick_a(1, 1);
        checks++;
        if (got_a !== e0) begin
            errors++; $display("FAIL en_restart: got %h want %h", got_a, e0);
        end
    endtask

    task automatic test_reset_mid_sync();
        vout_t ea, eb, e0;
        ea = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 3'b000};
        eb = {1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 3'b000};
        e0 = {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 3'b110};
        for (int k = 0; k < 700; k++) tick_a(1, 1);
        checks++;
        if (hs_a !== 1'b0) begin
            errors++; $display("FAIL pre_reset_hsync: got %b want 0", hs_a);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (got_a !== ea) begin
            errors++; $display("FAIL async_reset_a: got %h want %h", got_a, ea);
        end
        checks++;
        if (got_b !== eb) begin
            errors++; $display("FAIL async_reset_b: got %h want %h", got_b, eb);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick_a(1, 1);
        checks++;
        if (got_a !== e0) begin
            errors++; $display("FAIL post_reset_first: got %h want %h", got_a, e0);
        end
        en_a = 1'b0;
    endtask

    task automatic test_small_mode();
        int act_cnt, hs_cnt, vs_cnt, fs_cnt, bad_px;
        vout_t ewrap, evb;
        act_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; bad_px = 0;
        tick_b(0, 0);
        for (int k = 1; k <= 96; k++) begin
            tick_b(1, 1);
            checks++;
            if (got_b !== exp_b) begin
                errors++; $display("FAIL small_k%0d: got %h want %h", k, got_b, exp_b);
            end
            if (act_b === 1'b1) act_cnt++;
            if (hs_b === 1'b1) hs_cnt++;
            if (vs_b === 1'b1) vs_cnt++;
            if (fs_b === 1'b1) fs_cnt++;
            if (act_b !== 1'b1 && (px_b !== 4'd0 || py_b !== 4'd0)) bad_px++;
        end
        checks++;
        if (act_cnt != 24 || hs_cnt != 24 || vs_cnt != 16 || fs_cnt != 2 || bad_px != 0) begin
            errors++;
            $display("FAIL small_counts: act %0d hs %0d vs %0d fs %0d badpx %0d want 24 24 16 2 0",
                     act_cnt, hs_cnt, vs_cnt, fs_cnt, bad_px);
        end
        // now parked at (7,5); one advance must wrap to (0,0)
        ewrap = {1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 3'b110};
        evb   = {1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 3'b101};
        tick_b(1, 1);
        checks++;
        if (got_b !== ewrap) begin
            errors++; $display("FAIL wrap: got %h want %h", got_b, ewrap);
        end
        for (int k = 0; k < 24; k++) tick_b(1, 1);
        checks++;
        if (got_b !== evb) begin
            errors++; $display("FAIL vblank_start: got %h want %h", got_b, evb);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6000; k++) begin
            en_a = ($urandom % 97) != 0;
            ce_a = ($urandom % 3) != 0;
            en_b = ($urandom % 61) != 0;
            ce_b = ($urandom % 4) != 0;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (got_a !== exp_a) begin
                errors++; $display("FAIL rand_a_k%0d: got %h want %h", k, got_a, exp_a);
            end
            checks++;
            if (got_b !== exp_b) begin
                errors++; $display("FAIL rand_b_k%0d: got %h want %h", k, got_b, exp_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_ce_div4();
        test_en_drop();
        test_reset_mid_sync();
        test_small_mode();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
